regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 8, consecutive blocked cycles before the MDU starvation guard fires (range 1..255).
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 wb_we, wb_dest, wb_val  in  1/5/32  pipeline writeback request; cannot be stalled.
REQ-005 mdu_valid, mdu_dest, mdu_val  in  1/5/32  multi-cycle unit result offer.
REQ-006 mdu_ready  out  1  buffer can accept an MDU result this cycle.
REQ-007 issue_en, issue_dest  in  1/5  MDU operation issued; marks issue_dest pending.
REQ-008 src1, src2  in  5/5  decode-stage read addresses.
REQ-009 stall  out  1  decode must hold (RAW/WAW on pending register).
REQ-010 wb_hold  out  1  pipeline must hold writeback one cycle (starvation guard).
REQ-011 rf_we, rf_dest, rf_val  out  1/5/32  registered drive of the register-file write port.

Function
REQ-012 One-entry MDU buffer (valid bit, dest, value); mdu_ready = buffer empty, combinational.
REQ-013 MDU beat accepted when mdu_valid && mdu_ready at a rising edge; buffer loaded that edge.
REQ-014 Effective WB request: wb_we && wb_dest != 0 && !wb_hold; writes to r0 are discarded.
REQ-015 Grant per cycle: effective WB wins; else a full buffer drains; else idle.
REQ-016 Grant registered: rf_we/rf_dest/rf_val reflect the winner one cycle after the request (latency 1); rf_we = 0 when idle.
REQ-017 Buffer drain and a new acceptance never occur in the same cycle (no bypass); minimum MDU throughput: one result per 2 cycles.
REQ-018 Scoreboard busy[31:1]; busy[0] is constant 0.
REQ-019 issue_en && issue_dest != 0 sets busy[issue_dest] at the edge.
REQ-020 Buffer drain clears busy[buffer dest] at the same edge the grant is registered.
REQ-021 Set and clear of the same index in one cycle: set wins.
REQ-022 WB writes never modify busy.
REQ-023 stall = busy[src1] | busy[src2] | busy[issue_dest], combinational.
REQ-024 Issuer never issues while stall is high; behaviour in that case is unspecified.

Reset
REQ-025 rst low at a rising edge: buffer empty, busy all 0, rf_we 0, rf_dest 0, rf_val 0, starvation counter 0, wb_hold 0.
REQ-026 Reset mid-operation discards any buffered MDU result without writing it; mdu_ready = 1 on the first cycle after reset release.

Configuration
REQ-027 Macro STARVE_GUARD_EN defined: an 8-bit counter increments each cycle the buffer is full and loses to WB, and clears on drain or reset.
REQ-028 With the macro, wb_hold is registered high for exactly one cycle when the counter reaches STARVE_LIMIT; the buffer drains that cycle, and the counter then clears.
REQ-029 Without the macro: no counter, wb_hold tied 0, WB has absolute priority.

Verification
REQ-030 Reset: hold rst=0 2 cycles with mdu_valid=1 -> rf_we=0, busy=0, mdu_ready=1 after release.
REQ-031 Solo MDU: issue_en, dest=5; later mdu_valid, dest=5, val=0xDEADBEEF -> stall high for src1=5 until the drain edge; rf_we=1, rf_dest=5, rf_val=0xDEADBEEF exactly 2 cycles after acceptance.
REQ-032 Conflict: buffer full (dest 7), wb_we=1 dest 3 val 0x11 for 3 cycles -> rf_dest=3 for 3 cycles, then rf_dest=7; mdu_ready low throughout.
REQ-033 r0 and set-wins: wb_dest=0 -> rf_we=0; issue dest=9 on the cycle the buffer drains dest 9 -> busy[9] remains 1.
REQ-034 STARVE_GUARD_EN, STARVE_LIMIT=4: continuous WB with buffer full -> wb_hold pulses one cycle after 4 blocked cycles and the buffer drains; undefined macro -> buffer never drains while WB is continuous.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: uncancellable writeback vs. a one-entry MDU result buffer,
// plus a pending-destination scoreboard for decode stalls. Optional guard macro: STARVE_GUARD_EN.
module regfile_write_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_val,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_dest,
    input  logic [31:0] mdu_val,
    output logic        mdu_ready,
    input  logic        issue_en,
    input  logic [4:0]  issue_dest,
    input  logic [4:0]  src1,
    input  logic [4:0]  src2,
    output logic        stall,
    output logic        wb_hold,
    output logic        rf_we,
    output logic [4:0]  rf_dest,
    output logic [31:0] rf_val
);

    logic        buf_vld_q, buf_vld_d;
    logic [4:0]  buf_dest_q, buf_dest_d;
    logic [31:0] buf_val_q, buf_val_d;
    logic [31:1] busy_q, busy_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_dest_q, rf_dest_d;
    logic [31:0] rf_val_q, rf_val_d;

    logic        eff_wb, drain, accept;
    logic [31:0] busy_all, busy_all_d;

    assign mdu_ready = !buf_vld_q;
    assign busy_all  = {busy_q, 1'b0};
    assign stall     = busy_all[src1] | busy_all[src2] | busy_all[issue_dest];
    assign rf_we     = rf_we_q;
    assign rf_dest   = rf_dest_q;
    assign rf_val    = rf_val_q;

    // Acceptance needs an empty buffer and drain needs a full one, so they never coincide.
    assign eff_wb = wb_we && (wb_dest != 5'd0) && !wb_hold;
    assign drain  = buf_vld_q && !eff_wb;
    assign accept = mdu_valid && !buf_vld_q;

    always_comb begin
        buf_vld_d  = buf_vld_q;
        buf_dest_d = buf_dest_q;
        buf_val_d  = buf_val_q;
        if (accept) begin
            buf_vld_d  = 1'b1;
            buf_dest_d = mdu_dest;
            buf_val_d  = mdu_val;
        end else if (drain) begin
            buf_vld_d = 1'b0;
        end
    end

    // Clear first so that a same-cycle issue to the draining index keeps it pending.
    always_comb begin
        busy_all_d = busy_all;
        if (drain)
            busy_all_d[buf_dest_q] = 1'b0;
        if (issue_en && (issue_dest != 5'd0))
            busy_all_d[issue_dest] = 1'b1;
        busy_d = busy_all_d[31:1];
    end

    always_comb begin
        rf_we_d   = 1'b0;
        rf_dest_d = 5'd0;
        rf_val_d  = 32'd0;
        if (eff_wb) begin
            rf_we_d   = 1'b1;
            rf_dest_d = wb_dest;
            rf_val_d  = wb_val;
        end else if (drain) begin
            rf_we_d   = 1'b1;
            rf_dest_d = buf_dest_q;
            rf_val_d  = buf_val_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_vld_q  <= 1'b0;
            buf_dest_q <= 5'd0;
            buf_val_q  <= 32'd0;
            busy_q     <= '0;
            rf_we_q    <= 1'b0;
            rf_dest_q  <= 5'd0;
            rf_val_q   <= 32'd0;
        end else begin
            buf_vld_q  <= buf_vld_d;
            buf_dest_q <= buf_dest_d;
            buf_val_q  <= buf_val_d;
            busy_q     <= busy_d;
            rf_we_q    <= rf_we_d;
            rf_dest_q  <= rf_dest_d;
            rf_val_q   <= rf_val_d;
        end
    end

`ifdef STARVE_GUARD_EN
    logic [7:0] starve_cnt_q, starve_cnt_d;
    logic       wb_hold_q, wb_hold_d;

    assign wb_hold = wb_hold_q;

    // Hold is raised on the edge that completes the LIMIT-th blocked cycle, forcing a drain next cycle.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        wb_hold_d    = 1'b0;
        if (drain) begin
            starve_cnt_d = 8'd0;
        end else if (buf_vld_q && eff_wb) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
            wb_hold_d    = (starve_cnt_q == 8'(STARVE_LIMIT - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt_q <= 8'd0;
            wb_hold_q    <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            wb_hold_q    <= wb_hold_d;
        end
    end
`else
    assign wb_hold = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; expected register-file writes are queued at drive
// time and compared by a monitor when rf_we is observed.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_dest;
    logic [31:0] wb_val;
    logic        mdu_valid;
    logic [4:0]  mdu_dest;
    logic [31:0] mdu_val;
    logic        mdu_ready;
    logic        issue_en;
    logic [4:0]  issue_dest;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic        stall;
    logic        wb_hold;
    logic        rf_we;
    logic [4:0]  rf_dest;
    logic [31:0] rf_val;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] val;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    regfile_write_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_dest(wb_dest), .wb_val(wb_val),
        .mdu_valid(mdu_valid), .mdu_dest(mdu_dest), .mdu_val(mdu_val), .mdu_ready(mdu_ready),
        .issue_en(issue_en), .issue_dest(issue_dest),
        .src1(src1), .src2(src2), .stall(stall), .wb_hold(wb_hold),
        .rf_we(rf_we), .rf_dest(rf_dest), .rf_val(rf_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] d, input logic [31:0] v);
        wr_t e;
        e.dest = d;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {63'd0, rf_we}, 64'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("sb_rf_dest", {59'd0, rf_dest}, {59'd0, e.dest});
                chk("sb_rf_val", {32'd0, rf_val}, {32'd0, e.val});
            end
        end
    end

    initial begin
        rst = 1'b0; wb_we = 1'b0; wb_dest = 5'd0; wb_val = 32'd0;
        mdu_valid = 1'b1; mdu_dest = 5'd4; mdu_val = 32'h4444_4444;
        issue_en = 1'b0; issue_dest = 5'd0; src1 = 5'd0; src2 = 5'd0;

        // reset held two cycles with an MDU offer pending
        step();
        step();
        chk("rst_rf_we", {63'd0, rf_we}, 64'd0);
        chk("rst_rf_dest", {59'd0, rf_dest}, 64'd0);
        chk("rst_rf_val", {32'd0, rf_val}, 64'd0);
        mdu_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mdu_ready", {63'd0, mdu_ready}, 64'd1);
        chk("rst_wb_hold", {63'd0, wb_hold}, 64'd0);
        for (int i = 0; i < 32; i += 8) begin
            src1 = 5'(i); src2 = 5'(i + 3); issue_dest = 5'(i + 5);
            #1;
            chk("rst_stall_clear", {63'd0, stall}, 64'd0);
        end
        src1 = 5'd0; src2 = 5'd0; issue_dest = 5'd0;
        step();
        chk("rst_no_write", {63'd0, rf_we}, 64'd0);

        // solo MDU result to r5
        issue_en = 1'b1; issue_dest = 5'd5;
        step();
        issue_en = 1'b0; issue_dest = 5'd0; src1 = 5'd5;
        #1;
        chk("solo_stall_pending", {63'd0, stall}, 64'd1);
        mdu_valid = 1'b1; mdu_dest = 5'd5; mdu_val = 32'hDEAD_BEEF;
        push(5'd5, 32'hDEAD_BEEF);
        step();
        mdu_valid = 1'b0;
        chk("solo_accept_no_write", {63'd0, rf_we}, 64'd0);
        chk("solo_ready_low", {63'd0, mdu_ready}, 64'd0);
        chk("solo_stall_held", {63'd0, stall}, 64'd1);
        step();
        chk("solo_rf_we", {63'd0, rf_we}, 64'd1);
        chk("solo_rf_dest", {59'd0, rf_dest}, 64'd5);
        chk("solo_rf_val", {32'd0, rf_val}, 64'hDEAD_BEEF);
        chk("solo_stall_cleared", {63'd0, stall}, 64'd0);
        chk("solo_ready_back", {63'd0, mdu_ready}, 64'd1);
        src1 = 5'd0;
        step();
        chk("solo_idle", {63'd0, rf_we}, 64'd0);

        // buffer full with r7 while writeback to r3 runs for three cycles
        mdu_valid = 1'b1; mdu_dest = 5'd7; mdu_val = 32'h0000_0077;
        step();
        mdu_valid = 1'b0;
        chk("conf_ready_low0", {63'd0, mdu_ready}, 64'd0);
        wb_we = 1'b1; wb_dest = 5'd3; wb_val = 32'h11;
        for (int i = 0; i < 3; i++) begin
            push(5'd3, 32'h11);
            step();
            chk("conf_wb_dest", {59'd0, rf_dest}, 64'd3);
            chk("conf_ready_low", {63'd0, mdu_ready}, 64'd0);
        end
        wb_we = 1'b0;
        push(5'd7, 32'h77);
        step();
        chk("conf_mdu_we", {63'd0, rf_we}, 64'd1);
        chk("conf_mdu_dest", {59'd0, rf_dest}, 64'd7);
        chk("conf_ready_back", {63'd0, mdu_ready}, 64'd1);

        // writeback to r0 is dropped
        wb_we = 1'b1; wb_dest = 5'd0; wb_val = 32'h55;
        step();
        wb_we = 1'b0;
        chk("r0_no_write", {63'd0, rf_we}, 64'd0);

        // issue to r9 on the same cycle r9 drains: pending bit survives
        issue_en = 1'b1; issue_dest = 5'd9;
        step();
        issue_en = 1'b0;
        mdu_valid = 1'b1; mdu_dest = 5'd9; mdu_val = 32'h99;
        push(5'd9, 32'h99);
        step();
        mdu_valid = 1'b0;
        issue_en = 1'b1; issue_dest = 5'd9;
        step();
        issue_en = 1'b0; issue_dest = 5'd0;
        chk("setwin_drain_dest", {59'd0, rf_dest}, 64'd9);
        src2 = 5'd9;
        #1;
        chk("setwin_busy_kept", {63'd0, stall}, 64'd1);
        mdu_valid = 1'b1; mdu_dest = 5'd9; mdu_val = 32'h9A;
        push(5'd9, 32'h9A);
        step();
        mdu_valid = 1'b0;
        step();
        chk("setwin_busy_cleared", {63'd0, stall}, 64'd0);
        src2 = 5'd0;

        // continuous writeback against a full buffer
        mdu_valid = 1'b1; mdu_dest = 5'd12; mdu_val = 32'h0C0C_0C0C;
        step();
        mdu_valid = 1'b0;
        wb_we = 1'b1; wb_dest = 5'd1; wb_val = 32'hABCD;
`ifdef STARVE_GUARD_EN
        for (int i = 0; i < 4; i++) begin
            push(5'd1, 32'hABCD);
            step();
            chk("starve_hold", {63'd0, wb_hold}, (i == 3) ? 64'd1 : 64'd0);
        end
        push(5'd12, 32'h0C0C_0C0C);
        step();
        chk("starve_drain_dest", {59'd0, rf_dest}, 64'd12);
        chk("starve_hold_end", {63'd0, wb_hold}, 64'd0);
        push(5'd1, 32'hABCD);
        step();
        wb_we = 1'b0;
        chk("starve_wb_resume", {59'd0, rf_dest}, 64'd1);
`else
        for (int i = 0; i < 8; i++) begin
            push(5'd1, 32'hABCD);
            step();
            chk("starve_ready_low", {63'd0, mdu_ready}, 64'd0);
            chk("starve_no_hold", {63'd0, wb_hold}, 64'd0);
        end
        wb_we = 1'b0;
        push(5'd12, 32'h0C0C_0C0C);
        step();
        chk("starve_late_drain", {59'd0, rf_dest}, 64'd12);
`endif
        step();
        step();
        chk("sb_all_writes_seen", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
